// File: rtl/rx_buf_rd_arb.sv
// rx_buf_rd_arb: round-robin arbiter for the single rx_buf read port.
//
// Up to NREQ readers (frame-header reader, address reader, rx bus control) share the port.
// One requester is granted at a time. Its read strobe and address are muxed onto rx_buf, and the
// returned data is qualified back to it with a one-hot read-valid strobe RD_LAT cycles later.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   req               per-requester level request, held for the whole burst
//   req_rd            per-requester read strobe (one read per cycle)
//   req_addr          per-requester address, slice i = [i*AW +: AW]
//   gnt               registered one-hot grant
//   rd_vld            one-hot read-data-valid, RD_LAT cycles after an accepted read
//   rd_data           rx_buf_rdata passed through, qualified by rd_vld
//   rx_buf_rden       read enable to rx_buf
//   rx_buf_raddr      read address to rx_buf
//   rx_buf_rdata      read data from rx_buf
//   arb_timeout       one-cycle pulse when a grant is force-released
//
// Build option
//   RX_ARB_TIMEOUT_EN  when defined, a grant held for TIMEOUT cycles is force-released.
//                      When undefined, grants are held indefinitely and arb_timeout is tied 0.
module rx_buf_rd_arb #(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned AW      = 11,
  parameter int unsigned DW      = 8,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned TIMEOUT = 2048
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_rd,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rd_vld,
  output logic [DW-1:0]      rd_data,
  output logic               rx_buf_rden,
  output logic [AW-1:0]      rx_buf_raddr,
  input  logic [DW-1:0]      rx_buf_rdata,
  output logic               arb_timeout
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Elaboration-time range check; the grant counter is 12 bits wide.
  if (NREQ < 2 || NREQ > 8 || RD_LAT < 1 || RD_LAT > 4 || TIMEOUT < 2 || TIMEOUT > 4096)
  begin : g_param_err
    $error("rx_buf_rd_arb: parameter out of range");
  end

  typedef enum logic [1:0] {StIdle, StGrant, StDrain} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     gidx_q, gidx_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [1:0]        drain_cnt_q, drain_cnt_d;
  logic [NREQ-1:0]   vld_q [RD_LAT];
  logic [NREQ-1:0]   vld_d [RD_LAT];
  logic              timeout_hit;
  logic [AW-1:0]     addr_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_addr
    assign addr_arr[i] = req_addr[i*AW +: AW];
  end

  // First set request searching upward from p, wrapping at NREQ-1.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] res;
    logic [31:0]   idx;
    logic          found;
    res   = p;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(p) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && r[idx[IW-1:0]]) begin
        found = 1'b1;
        res   = idx[IW-1:0];
      end
    end
    return res;
  endfunction

  function automatic logic [NREQ-1:0] to_onehot(input logic [IW-1:0] i);
    logic [NREQ-1:0] o;
    o    = '0;
    o[i] = 1'b1;
    return o;
  endfunction

`ifdef RX_ARB_TIMEOUT_EN
  logic [11:0] tcnt_q, tcnt_d;

  // Cleared while idle so it starts at 0 on the first GRANT cycle.
  always_comb begin
    tcnt_d = tcnt_q;
    if (state_q == StIdle) begin
      tcnt_d = '0;
    end else if (state_q == StGrant) begin
      tcnt_d = tcnt_q + 12'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  assign timeout_hit = (state_q == StGrant) && (tcnt_q == 12'(TIMEOUT - 1));
  assign arb_timeout = timeout_hit;
`else
  assign timeout_hit = 1'b0;
  assign arb_timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gidx_d       = gidx_q;
    gnt_d        = gnt_q;
    drain_cnt_d  = drain_cnt_q;
    rx_buf_rden  = 1'b0;
    rx_buf_raddr = '0;
    case (state_q)
      StIdle: begin
        if (|req) begin
          gidx_d  = rr_pick(req, ptr_q);
          gnt_d   = to_onehot(gidx_d);
          state_d = StGrant;
        end
      end
      StGrant: begin
        rx_buf_raddr = addr_arr[gidx_q];
        if (!req[gidx_q] || timeout_hit) begin
          // Release: no read this cycle, rotate priority past the current owner.
          gnt_d       = '0;
          drain_cnt_d = '0;
          ptr_d       = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
          state_d     = StDrain;
        end else begin
          rx_buf_rden = req_rd[gidx_q];
        end
      end
      StDrain: begin
        // Hold off the next grant until in-flight data has reached its owner.
        if (drain_cnt_q == 2'(RD_LAT - 1)) begin
          state_d = StIdle;
        end else begin
          drain_cnt_d = drain_cnt_q + 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Issuer pipeline: gnt_q is the one-hot owner whenever rden can be high.
  always_comb begin
    vld_d[0] = rx_buf_rden ? gnt_q : '0;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      gidx_q      <= '0;
      gnt_q       <= '0;
      drain_cnt_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        vld_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      gnt_q       <= gnt_d;
      drain_cnt_q <= drain_cnt_d;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        vld_q[i] <= vld_d[i];
      end
    end
  end

  assign gnt     = gnt_q;
  assign rd_vld  = vld_q[RD_LAT-1];
  assign rd_data = rx_buf_rdata;

endmodule

// File: tb/tb_rx_buf_rd_arb.sv
// Self-checking bench for rx_buf_rd_arb: directed scenarios followed by randomized traffic,
// every cycle compared against a cycle-count based reference model of the arbitration rules.
module tb_rx_buf_rd_arb;

  localparam int NREQ    = 3;
  localparam int AW      = 11;
  localparam int DW      = 8;
  localparam int RD_LAT  = 1;
  localparam int TIMEOUT = 16;
`ifdef RX_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req, req_rd, gnt, rd_vld;
  logic [NREQ*AW-1:0] req_addr;
  logic [DW-1:0]      rd_data, rx_buf_rdata;
  logic               rx_buf_rden;
  logic [AW-1:0]      rx_buf_raddr;
  logic               arb_timeout;

  rx_buf_rd_arb #(
    .NREQ   (NREQ),
    .AW     (AW),
    .DW     (DW),
    .RD_LAT (RD_LAT),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_rd      (req_rd),
    .req_addr    (req_addr),
    .gnt         (gnt),
    .rd_vld      (rd_vld),
    .rd_data     (rd_data),
    .rx_buf_rden (rx_buf_rden),
    .rx_buf_raddr(rx_buf_raddr),
    .rx_buf_rdata(rx_buf_rdata),
    .arb_timeout (arb_timeout)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  // Reference model: current owner (-1 = none), cycles it has held the grant, rotating
  // priority start, and the first cycle on which a new request may be picked up.
  int owner, held, ptr, decide_from;
  int iss_cyc[$];
  int iss_id[$];

  // Observation log of DUT grants and timeout pulses for the directed checks.
  logic [NREQ-1:0] prev_gnt;
  int g_start[$], g_end[$], g_val[$], to_q[$];
  logic [NREQ-1:0] obs_gnt, obs_vld;
  logic            obs_rden, obs_to;
  logic [AW-1:0]   obs_raddr;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [NREQ*AW-1:0] pack(input logic [AW-1:0] a2, input logic [AW-1:0] a1,
                                              input logic [AW-1:0] a0);
    return {a2, a1, a0};
  endfunction

  function automatic logic [NREQ*AW-1:0] rand_addr();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[NREQ*AW-1:0];
  endfunction

  task automatic model_reset();
    owner       = -1;
    held        = 0;
    ptr         = 0;
    decide_from = cyc;
    iss_cyc.delete();
    iss_id.delete();
  endtask

  task automatic clear_log();
    g_start.delete();
    g_end.delete();
    g_val.delete();
    to_q.delete();
  endtask

  // One clock cycle: drive inputs, check all outputs at the falling edge, advance the model.
  task automatic cycle(input logic rst, input logic [NREQ-1:0] r, input logic [NREQ-1:0] rd,
                       input logic [NREQ*AW-1:0] addr);
    int exp_gnt, exp_raddr, exp_vld;
    bit to_hit, rel, exp_rden;
    logic [NREQ*AW-1:0] sh;
    reset        = rst;
    req          = r;
    req_rd       = rd;
    req_addr     = addr;
    rx_buf_rdata = 8'($urandom);
    @(negedge clk);

    exp_gnt   = 0;
    exp_raddr = 0;
    to_hit    = 1'b0;
    rel       = 1'b0;
    exp_rden  = 1'b0;
    if (owner >= 0) begin
      exp_gnt   = 1 << owner;
      to_hit    = TO_EN && (held == TIMEOUT - 1);
      rel       = (((r >> owner) & 3'b001) == 3'b000) || to_hit;
      exp_rden  = !rel && (((rd >> owner) & 3'b001) != 3'b000);
      sh        = addr >> (owner * AW);
      exp_raddr = int'(sh[AW-1:0]);
    end
    exp_vld = 0;
    foreach (iss_cyc[k]) begin
      if (iss_cyc[k] == cyc - RD_LAT) exp_vld = exp_vld | (1 << iss_id[k]);
    end

    check_eq("gnt", 32'(gnt), exp_gnt);
    check_eq("rden", 32'(rx_buf_rden), 32'(exp_rden));
    check_eq("raddr", 32'(rx_buf_raddr), exp_raddr);
    check_eq("rd_vld", 32'(rd_vld), exp_vld);
    check_eq("rd_data", 32'(rd_data), 32'(rx_buf_rdata));
    check_eq("arb_timeout", 32'(arb_timeout), 32'(to_hit));

    obs_gnt   = gnt;
    obs_vld   = rd_vld;
    obs_rden  = rx_buf_rden;
    obs_raddr = rx_buf_raddr;
    obs_to    = arb_timeout;
    if (gnt != prev_gnt) begin
      if (prev_gnt != '0) g_end.push_back(cyc - 1);
      if (gnt != '0) begin
        g_start.push_back(cyc);
        g_val.push_back(int'(gnt));
      end
    end
    prev_gnt = gnt;
    if (arb_timeout) to_q.push_back(cyc);

    if (exp_rden) begin
      iss_cyc.push_back(cyc);
      iss_id.push_back(owner);
    end
    while (iss_cyc.size() > 0 && iss_cyc[0] <= cyc - RD_LAT) begin
      void'(iss_cyc.pop_front());
      void'(iss_id.pop_front());
    end
    if (rst) begin
      cyc = cyc + 1;
      model_reset();
      cyc = cyc - 1;
    end else if (owner >= 0) begin
      if (rel) begin
        ptr         = (owner + 1) % NREQ;
        owner       = -1;
        decide_from = cyc + RD_LAT + 1;
      end else begin
        held++;
      end
    end else if (cyc >= decide_from && r != '0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (owner < 0 && ((r >> ((ptr + k) % NREQ)) & 3'b001) != 3'b000) begin
          owner = (ptr + k) % NREQ;
          held  = 0;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int left[NREQ];
    bit on[NREQ];
    logic [NREQ-1:0] r, rd;

    reset        = 1'b1;
    req          = '0;
    req_rd       = '0;
    req_addr     = '0;
    rx_buf_rdata = '0;
    prev_gnt     = '0;
    repeat (2) @(posedge clk);
    #1;
    cyc = 0;
    model_reset();

    // Reset values, then single requester with RD_LAT=1 timing.
    cycle(1'b0, 3'b000, 3'b000, '0);
    check_eq("rst_gnt", 32'(obs_gnt), 0);
    check_eq("rst_rden", 32'(obs_rden), 0);
    check_eq("rst_raddr", 32'(obs_raddr), 0);
    check_eq("rst_vld", 32'(obs_vld), 0);
    check_eq("rst_timeout", 32'(obs_to), 0);
    cycle(1'b0, 3'b001, 3'b000, '0);
    check_eq("t1_gnt_latency", 32'(obs_gnt), 0);
    cycle(1'b0, 3'b001, 3'b000, pack(11'h0, 11'h0, 11'h010));
    check_eq("t1_gnt", 32'(obs_gnt), 1);
    cycle(1'b0, 3'b001, 3'b001, pack(11'h0, 11'h0, 11'h010));
    check_eq("t1_rden", 32'(obs_rden), 1);
    check_eq("t1_raddr", 32'(obs_raddr), 32'h010);
    cycle(1'b0, 3'b001, 3'b000, pack(11'h0, 11'h0, 11'h010));
    check_eq("t1_rd_vld", 32'(obs_vld), 1);

    // Request drops in the same cycle as a strobe: no read, grant gone next cycle.
    cycle(1'b0, 3'b000, 3'b001, pack(11'h0, 11'h0, 11'h010));
    check_eq("t4_rden", 32'(obs_rden), 0);
    cycle(1'b0, 3'b000, 3'b000, '0);
    check_eq("t4_gnt", 32'(obs_gnt), 0);
    check_eq("t4_vld", 32'(obs_vld), 0);
    cycle(1'b0, 3'b000, 3'b000, '0);

    // Strobe from a non-granted requester is ignored.
    cycle(1'b0, 3'b001, 3'b000, '0);
    cycle(1'b0, 3'b011, 3'b010, pack(11'h0, 11'h7FF, 11'h0));
    check_eq("t3_gnt", 32'(obs_gnt), 1);
    check_eq("t3_rden", 32'(obs_rden), 0);
    check_eq("t3_raddr", 32'(obs_raddr), 0);
    cycle(1'b0, 3'b011, 3'b010, pack(11'h0, 11'h7FF, 11'h0));
    check_eq("t3_vld", 32'(obs_vld), 0);

    // Reset during a read discards everything in flight.
    cycle(1'b0, 3'b011, 3'b001, pack(11'h0, 11'h7FF, 11'h123));
    check_eq("t5_rden", 32'(obs_rden), 1);
    check_eq("t5_raddr", 32'(obs_raddr), 32'h123);
    cycle(1'b1, 3'b011, 3'b001, pack(11'h0, 11'h7FF, 11'h123));
    cycle(1'b0, 3'b000, 3'b000, '0);
    check_eq("t5_gnt", 32'(obs_gnt), 0);
    check_eq("t5_rden_after", 32'(obs_rden), 0);
    check_eq("t5_vld", 32'(obs_vld), 0);

    // All three request together after reset; each leaves after 4 reads.
    clear_log();
    left = '{4, 4, 4};
    r    = 3'b111;
    for (int i = 0; i < 40; i++) begin
      rd = '0;
      if (owner >= 0) begin
        if (left[owner] > 0) begin
          rd = 3'(1 << owner);
          left[owner]--;
        end else begin
          r = r & ~3'(1 << owner);
        end
      end
      cycle(1'b0, r, rd, rand_addr());
    end
    check_eq("t2_ngrants", g_val.size(), 3);
    for (int k = 0; k < g_val.size() && k < 3; k++) check_eq("t2_order", g_val[k], 1 << k);
    for (int k = 0; k < 2 && k + 1 < g_start.size() && k < g_end.size(); k++) begin
      check_eq("t2_gap", g_start[k+1] - g_end[k], RD_LAT + 2);
    end

    // Requester 0 holds on while requester 1 waits.
    cycle(1'b1, 3'b000, 3'b000, '0);
    clear_log();
    for (int i = 0; i < 30; i++) cycle(1'b0, 3'b011, 3'($urandom), rand_addr());
`ifdef RX_ARB_TIMEOUT_EN
    check_eq("t6_pulses", to_q.size(), 1);
    if (to_q.size() > 0 && g_start.size() > 1 && g_end.size() > 0) begin
      check_eq("t6_pulse_cycle", to_q[0] - g_start[0], TIMEOUT - 1);
      check_eq("t6_drop", g_end[0], to_q[0]);
      check_eq("t6_regrant_cycle", g_start[1], to_q[0] + 3);
      check_eq("t6_regrant", g_val[1], 2);
    end
`else
    check_eq("t6_no_timeout", to_q.size(), 0);
    check_eq("t6_held", g_val.size(), 1);
`endif

    // Randomized bursts with occasional resets.
    cycle(1'b0, 3'b000, 3'b000, '0);
    for (int i = 0; i < NREQ; i++) begin
      on[i]   = 1'b0;
      left[i] = $urandom_range(0, 8);
    end
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (left[i] == 0) begin
          on[i]   = !on[i];
          left[i] = on[i] ? $urandom_range(1, 30) : $urandom_range(0, 8);
        end else begin
          left[i]--;
        end
        r[i] = on[i];
      end
      cycle($urandom_range(0, 299) == 0, r, 3'($urandom), rand_addr());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
